// File: rtl/serial_subtractor_seq_if.sv
// serial_subtractor_seq_if: operand/result handshake bundle for the serial subtractor
interface serial_subtractor_seq_if #(parameter int WIDTH = 8);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             borrow_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   modport master (output in_valid, a, b, borrow_in, out_ready,
                   input  in_ready, out_valid, diff, borrow);
   modport slave  (input  in_valid, a, b, borrow_in, out_ready,
                   output in_ready, out_valid, diff, borrow);
endinterface

// File: rtl/serial_subtractor_seq.sv
// serial_subtractor_seq: digit-serial A - B - borrow_in with a registered borrow chain
module serial_subtractor_seq #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input logic                    clk,
   input logic                    rst_n,
   serial_subtractor_seq_if.slave sb
);
   localparam int STEPS = WIDTH / DIGIT;
   localparam int CW = $clog2(STEPS + 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] a_sr, b_sr, diff_r;
   logic             br;
   logic [CW-1:0]    cnt;
   logic [DIGIT:0]   res;
   logic             last;
   // ripple the borrow through one digit of full-subtractor cells; MSB of result is borrow out
   function automatic logic [DIGIT:0] sub_digit(input logic [DIGIT-1:0] x, y, input logic bi);
      logic c;
      sub_digit = '0;
      c = bi;
      for (int i = 0; i < DIGIT; i++) begin
         sub_digit[i] = x[i] ^ y[i] ^ c;
         c = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & c);
      end
      sub_digit[DIGIT] = c;
   endfunction
   assign res  = sub_digit(a_sr[DIGIT-1:0], b_sr[DIGIT-1:0], br);
   assign last = cnt == CW'(STEPS - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      state_nx = state == IDLE ? (sb.in_valid ? RUN : IDLE) :
                 state == RUN  ? (last ? DONE : RUN) :
                 (sb.out_ready ? IDLE : DONE);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         diff_r <= '0;
         br     <= 1'b0;
         cnt    <= '0;
      end else if (state == IDLE && sb.in_valid) begin
         a_sr <= sb.a;
         b_sr <= sb.b;
         br   <= sb.borrow_in;
         cnt  <= '0;
      end else if (state == RUN) begin
         a_sr   <= a_sr >> DIGIT;
         b_sr   <= b_sr >> DIGIT;
         diff_r <= (diff_r >> DIGIT) | (WIDTH'(res[DIGIT-1:0]) << (WIDTH - DIGIT));
         br     <= res[DIGIT];
         cnt    <= cnt + 1'b1;
      end
   assign sb.in_ready  = state == IDLE;
   assign sb.out_valid = state == DONE;
   assign sb.diff      = diff_r;
   assign sb.borrow    = br;
endmodule
